// File: rtl/bpd_base_table_pkg.sv
// bpd_base_table_pkg: entry layout constants, controller state type and 2-bit saturating counter helpers
package bpd_base_table_pkg;
  localparam int ENTRY_W = 9;
  localparam int LANE_W = 2;
  localparam int VALID_BIT = 8;
  localparam logic [ENTRY_W-1:0] INIT_ENTRY = {1'b0, {4{2'b01}}};
  typedef enum logic {INIT, RUN} state_t;
  function automatic logic [2:0] lane_lsb(input logic [1:0] lane);
    return {lane, 1'b0};
  endfunction
  function automatic logic [1:0] sat2_update(input logic [1:0] c, input logic taken);
    return taken ? ((c == 2'd3) ? c : c + 2'd1) : ((c == 2'd0) ? c : c - 2'd1);
  endfunction
endpackage

// File: rtl/bpd_base_table_ctrl.sv
// bpd_base_table_ctrl: owns the base-table SRAM port; init sweep, lookups, and masked RMW counter updates with aged-read arbitration
module bpd_base_table_ctrl
  import bpd_base_table_pkg::*;
#(
  parameter int ENTRIES = 256,
  parameter int ADDR_W = 8,
  parameter logic [1:0] INIT_CTR = 2'b01
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               lkp_valid,
  output logic               lkp_ready,
  input  logic [ADDR_W-1:0]  lkp_addr,
  output logic               rsp_valid,
  output logic [ENTRY_W-1:0] rsp_data,
  input  logic               upd_valid,
  output logic               upd_ready,
  input  logic [ADDR_W-1:0]  upd_addr,
  input  logic [1:0]         upd_lane,
  input  logic               upd_taken,
  output logic               init_done,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_en,
  output logic               mem_wmode,
  output logic [ENTRY_W-1:0] mem_wdata,
  output logic [ENTRY_W-1:0] mem_wmask,
  input  logic [ENTRY_W-1:0] mem_rdata
);
  state_t state;
  logic [ADDR_W-1:0] sweep, buf_addr;
  logic [1:0] buf_lane, buf_age, new_ctr;
  logic buf_taken, buf_valid, buf_rd;
  logic act, sweeping, run, wr, rd, lkp_go;
  logic [ENTRY_W-1:0] valid_mask, lane_mask, upd_word;
  assign act = ~reset;
  assign sweeping = act & (state == INIT);
  assign run = act & (state == RUN);
  assign wr = run & buf_valid & buf_rd;
  assign rd = run & buf_valid & ~buf_rd & ((buf_age == 2'd3) | ~lkp_valid);
  assign lkp_go = run & lkp_valid & ~wr & ~rd;
  assign valid_mask = ENTRY_W'(1) << VALID_BIT;
  assign lane_mask = ENTRY_W'(3) << lane_lsb(buf_lane);
  assign new_ctr = sat2_update(LANE_W'(mem_rdata >> lane_lsb(buf_lane)), buf_taken);
  assign upd_word = valid_mask | (ENTRY_W'(new_ctr) << lane_lsb(buf_lane));
  assign lkp_ready = lkp_go;
  assign upd_ready = act & init_done & ~buf_valid;
  assign rsp_data = mem_rdata;
  always_comb begin
    mem_en = sweeping | wr | rd | lkp_go;
    mem_wmode = sweeping | wr;
    mem_addr = sweeping ? sweep : (wr | rd) ? buf_addr : lkp_go ? lkp_addr : '0;
    mem_wdata = sweeping ? {1'b0, {4{INIT_CTR}}} : wr ? upd_word : '0;
    mem_wmask = sweeping ? '1 : wr ? (valid_mask | lane_mask) : '0;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= INIT;
      sweep <= '0;
      init_done <= 1'b0;
      buf_valid <= 1'b0;
      buf_rd <= 1'b0;
      buf_age <= 2'd0;
      rsp_valid <= 1'b0;
    end else begin
      rsp_valid <= lkp_go;
      if (state == INIT) begin
        sweep <= (sweep == ADDR_W'(ENTRIES - 1)) ? '0 : sweep + 1'b1;
        if (sweep == ADDR_W'(ENTRIES - 1)) begin
          state <= RUN;
          init_done <= 1'b1;
        end
      end
      if (upd_valid & upd_ready) begin
        buf_valid <= 1'b1;
        buf_rd <= 1'b0;
        buf_age <= 2'd0;
        buf_addr <= upd_addr;
        buf_lane <= upd_lane;
        buf_taken <= upd_taken;
      end else if (wr) begin
        buf_valid <= 1'b0;
      end else if (rd) begin
        buf_rd <= 1'b1;
      end else if (buf_valid & ~buf_rd) begin
        buf_age <= buf_age + {1'b0, buf_age != 2'd3};
      end
    end
  end
endmodule

// File: tb/tb_bpd_base_table_ctrl.sv
// tb_bpd_base_table_ctrl: directed plus random stimulus checked against a deadline-based reference model of the base-table controller
module tb_bpd_base_table_ctrl;
  import bpd_base_table_pkg::*;
  logic clock = 1'b0, reset = 1'b1;
  logic lkp_valid = 1'b0, lkp_ready, rsp_valid, upd_valid = 1'b0, upd_ready, upd_taken = 1'b0, init_done;
  logic mem_en, mem_wmode;
  logic [7:0] lkp_addr = '0, upd_addr = '0, mem_addr;
  logic [1:0] upd_lane = '0;
  logic [8:0] rsp_data, mem_wdata, mem_wmask, mem_rdata, rdata_q;
  logic [8:0] sram [256];
  logic [8:0] tbl [256];
  int errs = 0, checks = 0, cyc = 0, p_acc = 0, p_rd = -1, ready_at;
  bit pend = 0, p_taken = 0, ev = 0, last_rv = 0, last_ur = 0;
  logic [7:0] p_addr = '0;
  logic [1:0] p_lane = '0;
  logic [8:0] ed = '0, last_rd = '0, last_wmask = '0;
  always #5 clock = ~clock;
  bpd_base_table_ctrl dut (
    .clock(clock), .reset(reset),
    .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_addr(lkp_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_addr(upd_addr),
    .upd_lane(upd_lane), .upd_taken(upd_taken), .init_done(init_done),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_wmode(mem_wmode),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );
  assign mem_rdata = rdata_q;
  always @(posedge clock) begin
    if (mem_en && !mem_wmode) rdata_q <= sram[mem_addr];
    if (mem_en && mem_wmode) sram[mem_addr] <= (sram[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run_cycle(input bit lv, input logic [7:0] la, input bit uv, input logic [7:0] ua, input logic [1:0] ul, input bit ut);
    bit ur, e_lr, e_en, e_wm, nev;
    logic [7:0] e_addr;
    logic [8:0] e_wd, e_mk, ned;
    int c, n;
    lkp_valid = lv; lkp_addr = la; upd_valid = uv; upd_addr = ua; upd_lane = ul; upd_taken = ut;
    ur = !pend; e_lr = 0; e_en = 0; e_wm = 0; e_addr = '0; e_wd = '0; e_mk = '0; nev = 0; ned = '0;
    if (pend && p_rd >= 0) begin
      c = int'((tbl[p_addr] >> (2 * p_lane)) & 9'd3);
      n = p_taken ? (c < 3 ? c + 1 : 3) : (c > 0 ? c - 1 : 0);
      e_en = 1; e_wm = 1; e_addr = p_addr;
      e_mk = 9'h100 | (9'd3 << (2 * p_lane));
      e_wd = 9'h100 | (9'(n) << (2 * p_lane));
      tbl[p_addr] = (tbl[p_addr] & ~e_mk) | e_wd;
      pend = 0;
    end else if (pend && (!lv || cyc - p_acc >= 4)) begin
      e_en = 1; e_addr = p_addr; p_rd = cyc;
    end else if (lv) begin
      e_lr = 1; e_en = 1; e_addr = la; nev = 1; ned = tbl[la];
    end
    if (uv && ur) begin
      pend = 1; p_addr = ua; p_lane = ul; p_taken = ut; p_acc = cyc; p_rd = -1;
    end
    @(negedge clock);
    chk("ctl", 64'({lkp_ready, upd_ready, init_done, mem_en, mem_wmode, mem_addr, mem_wdata, mem_wmask}),
        64'({e_lr, ur, 1'b1, e_en, e_wm, e_addr, e_wd, e_mk}));
    chk("rsp_valid", 64'(rsp_valid), 64'(ev));
    if (ev) chk("rsp_data", 64'(rsp_data), 64'(ed));
    last_rv = rsp_valid; last_rd = rsp_data; last_wmask = mem_wmask; last_ur = upd_ready;
    ev = nev; ed = ned; cyc++;
    @(posedge clock); #1;
  endtask
  task automatic idle();
    run_cycle(0, '0, 0, '0, '0, 0);
  endtask
  task automatic lkp(input logic [7:0] a);
    run_cycle(1, a, 0, '0, '0, 0);
  endtask
  task automatic upd(input logic [7:0] a, input logic [1:0] l, input bit t);
    run_cycle(0, '0, 1, a, l, t);
  endtask
  task automatic reset_and_sweep();
    reset = 1; lkp_valid = 1; upd_valid = 1;
    @(negedge clock);
    chk("rst_abort", 64'({lkp_ready, upd_ready, mem_en}), 64'(0));
    @(posedge clock); #1;
    @(negedge clock);
    chk("rst_state", 64'({lkp_ready, upd_ready, init_done, mem_en, rsp_valid}), 64'(0));
    @(posedge clock); #1;
    reset = 0;
    for (int i = 0; i < 256; i++) begin
      lkp_valid = 1'($urandom); upd_valid = 1'($urandom);
      lkp_addr = 8'($urandom); upd_addr = 8'($urandom);
      @(negedge clock);
      chk("sweep", 64'({lkp_ready, upd_ready, init_done, mem_en, mem_wmode, mem_addr, mem_wdata, mem_wmask, rsp_valid}),
          64'({5'b00011, 8'(i), INIT_ENTRY, 9'h1FF, 1'b0}));
      @(posedge clock); #1;
    end
    for (int i = 0; i < 256; i++) tbl[i] = 9'h055;
    pend = 0; ev = 0; cyc = 0;
  endtask
  initial begin
    reset_and_sweep();
    lkp(8'h10);
    idle();
    chk("lkp10", 64'({last_rv, last_rd}), 64'({1'b1, 9'h055}));
    upd(8'h10, 2'd2, 1);
    idle();
    idle();
    chk("wmask", 64'(last_wmask), 64'(9'h130));
    idle();
    upd(8'h10, 2'd2, 1);
    repeat (3) idle();
    lkp(8'h10);
    idle();
    chk("taken2", 64'(last_rd), 64'(9'h175));
    upd(8'h10, 2'd2, 1);
    repeat (3) idle();
    lkp(8'h10);
    idle();
    chk("sat_hi", 64'(last_rd), 64'(9'h175));
    repeat (5) begin
      upd(8'h10, 2'd2, 0);
      repeat (3) idle();
    end
    lkp(8'h10);
    idle();
    chk("sat_lo", 64'(last_rd), 64'(9'h145));
    upd(8'h20, 2'd0, 1);
    idle();
    lkp(8'h20);
    lkp(8'h20);
    idle();
    chk("raw", 64'(last_rd), 64'(9'h156));
    run_cycle(1, 8'h01, 1, 8'h30, 2'd1, 1);
    ready_at = -1;
    for (int k = 1; k <= 10; k++) begin
      run_cycle(1, 8'($urandom_range(0, 15)), k == 1, 8'h31, 2'd3, 0);
      if (ready_at < 0 && last_ur) ready_at = k;
    end
    chk("ready_ret", 64'(ready_at > 0 && ready_at <= 6), 64'(1));
    repeat (600)
      run_cycle($urandom_range(0, 9) < 7, 8'($urandom_range(0, 15)), $urandom_range(0, 3) == 0,
                8'($urandom_range(0, 15)), 2'($urandom), 1'($urandom));
    repeat (8) idle();
    upd(8'h40, 2'd3, 1);
    idle();
    reset_and_sweep();
    repeat (6) idle();
    lkp(8'h40);
    idle();
    chk("abort_drop", 64'({last_rv, last_rd}), 64'({1'b1, 9'h055}));
    repeat (200)
      run_cycle($urandom_range(0, 9) < 6, 8'($urandom_range(0, 7)), $urandom_range(0, 2) == 0,
                8'($urandom_range(0, 7)), 2'($urandom), 1'($urandom));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
